chan_scan_seq: RTL and testbench

Channel-scan sequencer that sits directly upstream of the 3-to-8 enable decoder. It walks a 3-bit channel select across the channels enabled in a mask and holds each selection for a programmable dwell time. It drives the decoder's `datain`/`en` pair with a one-cycle break-before-make gap between channels. Single-pass and continuous modes are supported, with a start/stop handshake and a completion pulse.

---
 rtl/chan_scan_pkg.sv | 14 +
 rtl/chan_scan_seq_if.sv | 28 ++
 rtl/scan_next_ch.sv | 29 ++
 rtl/chan_scan_seq.sv | 118 +++++++++++
 tb/tb_chan_scan_seq.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/chan_scan_pkg.sv
// Shared types and constants for the channel-scan sequencer.
// Sized to match the 3-to-8 enable decoder downstream.
package chan_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_t;

endpackage

// File: rtl/chan_scan_seq_if.sv
// Control and decoder-side bundle for chan_scan_seq.
// The master drives the scan request; the slave drives the decoder pair.
interface chan_scan_seq_if #(
  parameter int DWELL_W = 8
);
  import chan_scan_pkg::*;

  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_CH-1:0]  ch_mask;
  logic [CH_W-1:0]    datain;
  logic               en;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode, dwell, ch_mask,
    input  datain, en, busy, done
  );

  modport slave (
    input  start, stop, mode, dwell, ch_mask,
    output datain, en, busy, done
  );

endinterface

// File: rtl/scan_next_ch.sv
// Mask search: lowest set channel above cur, and lowest set overall.
// Purely combinational.
module scan_next_ch
  import chan_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   nxt,
  output logic              found,
  output logic [CH_W-1:0]   first
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    first = '0;
    // Descending walk: the last hit is the lowest index.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = CH_W'(i);
        if (i > int'(cur)) begin
          nxt   = CH_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/chan_scan_seq.sv
// Channel-scan sequencer: walks enabled channels with a dwell
// and a one-cycle break-before-make gap, feeding a 3-to-8 decoder.
module chan_scan_seq #(
  parameter int NUM_CH  = 8,
  parameter int DWELL_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  chan_scan_seq_if.slave  bus
);
  import chan_scan_pkg::*;

  state_t             st, st_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dw, dw_n, dsel;
  logic [NUM_CH-1:0]  mask, mask_n, msel;
  logic               mode_q, mode_n;
  logic [CH_W-1:0]    ch, ch_n;
  logic [CH_W-1:0]    nxt, first;
  logic               found;
  logic               en_q, en_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;

  assign dsel = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  // Search the live mask only when choosing the first channel.
  assign msel = (st == IDLE) ? bus.ch_mask : mask;

  scan_next_ch u_next (
    .mask  (msel),
    .cur   (ch),
    .nxt   (nxt),
    .found (found),
    .first (first)
  );

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    dw_n   = dw;
    mask_n = mask;
    mode_n = mode_q;
    ch_n   = ch;
    en_n   = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    unique case (st)
      IDLE: begin
        if (bus.start && !bus.stop &&
            bus.ch_mask != '0) begin
          st_n   = ACTIVE;
          dw_n   = dsel;
          mask_n = bus.ch_mask;
          mode_n = bus.mode;
          ch_n   = first;
          cnt_n  = dsel;
          en_n   = 1'b1;
          busy_n = 1'b1;
        end
      end
      ACTIVE: begin
        if (!bus.stop) begin
          busy_n = 1'b1;
          cnt_n  = cnt - DWELL_W'(1);
          if (cnt <= DWELL_W'(1)) st_n = GAP;
          else                    en_n = 1'b1;
        end else begin
          st_n = IDLE;
        end
      end
      GAP: begin
        if (bus.stop) begin
          st_n = IDLE;
        end else if (found || mode_q) begin
          st_n   = ACTIVE;
          ch_n   = found ? nxt : first;
          cnt_n  = dw;
          en_n   = 1'b1;
          busy_n = 1'b1;
        end else begin
          st_n   = IDLE;
          done_n = 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      dw     <= '0;
      mask   <= '0;
      mode_q <= 1'b0;
      ch     <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      dw     <= dw_n;
      mask   <= mask_n;
      mode_q <= mode_n;
      ch     <= ch_n;
      en_q   <= en_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.datain = ch;
  assign bus.en     = en_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_chan_scan_seq.sv
// Bench for chan_scan_seq: directed and random scans against a
// cycle-indexed arithmetic model of the scan schedule.
module tb_chan_scan_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chan_scan_seq_if #(.DWELL_W(8)) bus ();

  chan_scan_seq #(.NUM_CH(8), .DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int       n_cmp = 0;
  int       n_err = 0;
  logic [2:0] last_ch = 3'd0;
  int       chans[$];
  int       dd;
  bit       md;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {bus.en, bus.datain, bus.busy, bus.done};
  endfunction

  task automatic chk(input string tag,
                     input logic [5:0] act,
                     input logic [5:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, act, exp);
    end
  endtask

  // Output at cycle t after the accepting edge: {en,datain,busy,done}
  function automatic logic [5:0] model(int t, int stop_at);
    int per, k, idx, ph;
    logic [5:0] s;
    per = dd + 1;
    k   = chans.size();
    if (stop_at >= 0 && t > stop_at) begin
      s = model(stop_at, -1);
      return {1'b0, s[4:2], 2'b00};
    end
    idx = t / per;
    ph  = t % per;
    if (!md && idx >= k)
      return {1'b0, 3'(chans[k-1]), 1'b0, (t == k * per)};
    return {(ph < dd), 3'(chans[idx % k]), 1'b1, 1'b0};
  endfunction

  task automatic scan(input logic [7:0] m, input int d,
                      input bit mode, input int ncyc,
                      input int stop_at, input bit disturb);
    logic [5:0] e;
    chans.delete();
    for (int i = 0; i < 8; i++)
      if (m[i]) chans.push_back(i);
    dd = (d == 0) ? 1 : d;
    md = mode;
    bus.ch_mask = m;
    bus.dwell   = 8'(d);
    bus.mode    = mode;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      e = model(t, stop_at);
      chk($sformatf("scan m=%h d=%0d t=%0d", m, d, t), obs(), e);
      last_ch  = e[4:2];
      bus.stop = (t == stop_at);
      if (disturb) begin
        bus.ch_mask = 8'($urandom);
        bus.dwell   = 8'($urandom_range(0, 9));
        bus.mode    = 1'($urandom);
        bus.start   = e[1] & 1'($urandom);
      end
      if (t < ncyc - 1) tick();
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    int d, k, p;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.mode    = 1'b0;
    bus.dwell   = 8'd0;
    bus.ch_mask = 8'd0;
    #12;
    chk("reset", obs(), 6'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_reset", obs(), 6'd0);

    scan(8'hFF, 2, 1'b0, 26, -1, 1'b0);
    scan(8'hA4, 0, 1'b0, 8, -1, 1'b0);
    scan(8'h81, 3, 1'b1, 16, 13, 1'b0);

    tick();
    bus.ch_mask = 8'h00;
    bus.start   = 1'b1;
    repeat (3) begin
      tick();
      chk("zero_mask", obs(), {1'b0, last_ch, 2'b00});
    end
    bus.ch_mask = 8'h05;
    bus.stop    = 1'b1;
    repeat (2) begin
      tick();
      chk("start_stop", obs(), {1'b0, last_ch, 2'b00});
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick();

    scan(8'h5A, 2, 1'b0, 14, -1, 1'b1);
    tick();

    // Each next scan is requested in the done cycle of the previous one.
    repeat (6) begin
      m = 8'($urandom_range(1, 255));
      d = $urandom_range(0, 4);
      k = $countones(m);
      p = ((d == 0) ? 1 : d) + 1;
      scan(m, d, 1'b0, k * p + 1, -1, 1'b0);
    end

    bus.ch_mask = 8'hFF;
    bus.dwell   = 8'd5;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("pre_async_rst", obs(), {1'b1, 3'd0, 2'b10});
    #2 rst = 1'b1;
    #1 chk("async_rst", obs(), 6'd0);
    last_ch = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("after_rst", obs(), 6'd0);
    scan(8'h18, 1, 1'b0, 6, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
